// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the single-cycle processor.
// Assembles little-endian 32-bit words from a 0xA5 / N / payload / XOR-checksum
// frame, writes them to instruction memory from word address 0 and raises
// `run` only once the whole frame has arrived with a good checksum.
//
// Ports:
//   clk, rst            system clock (rising edge), async active-low reset
//   in_valid/in_ready   byte-stream handshake, in_byte carries the data
//   clr                 one-cycle pulse that leaves ERROR
//   im_we/im_addr/im_wdata  instruction-memory write port (one-cycle pulse)
//   run, done, err      processor start level, DONE and ERROR indicators
//   err_code            01 checksum mismatch, 10 timeout, 00 otherwise
//   words_loaded        words written in the current or last frame
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for 0xA5 header, other bytes discarded
// COUNT   | waiting for the word count N (0 means 2^ADDR_W)
// DATA    | collecting payload bytes, writing each completed word
// CHECK   | waiting for the XOR checksum byte
// DONE    | program valid, run=1; a new 0xA5 starts a reload
// ERROR   | checksum or timeout failure, in_ready=0 until clr
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              clr,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              run,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t          state;
  logic [ADDR_W:0] total;
  logic [1:0]      bidx;
  logic [7:0]      csum;
  logic [23:0]     asm_q;
  logic [CW-1:0]   idle_cnt;

  logic accept;
  logic in_frame;
  logic timed_out;

  assign in_ready  = (state != S_ERROR);
  assign accept    = in_valid && in_ready;
  assign in_frame  = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  // An accepted byte in the cycle the counter sits at TIMEOUT wins over the abort.
  assign timed_out = in_frame && !accept && (idle_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      total        <= '0;
      bidx         <= '0;
      csum         <= '0;
      asm_q        <= '0;
      idle_cnt     <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      run          <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;
      // Address advances on the edge that ends a write pulse, so it is stable
      // for the whole pulse; for N=0 this wraps 255->0 after the last write.
      if (im_we) im_addr <= im_addr + 1'b1;

      if (!in_frame || accept) idle_cnt <= '0;
      else                     idle_cnt <= idle_cnt + 1'b1;

      if (timed_out) begin
        state    <= S_ERROR;
        err      <= 1'b1;
        err_code <= 2'b10;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && in_byte == 8'hA5) state <= S_COUNT;
          end
          S_COUNT: begin
            if (accept) begin
              total        <= (in_byte == 8'h00) ? {1'b1, {ADDR_W{1'b0}}}
                                                 : (ADDR_W+1)'(in_byte);
              im_addr      <= '0;
              words_loaded <= '0;
              bidx         <= '0;
              csum         <= '0;
              state        <= S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              csum <= csum ^ in_byte;
              bidx <= bidx + 1'b1;
              case (bidx)
                2'd0: asm_q[7:0]   <= in_byte;
                2'd1: asm_q[15:8]  <= in_byte;
                2'd2: asm_q[23:16] <= in_byte;
                default: begin
                  im_wdata     <= {in_byte, asm_q};
                  im_we        <= 1'b1;
                  words_loaded <= words_loaded + 1'b1;
                  if (words_loaded + (ADDR_W+1)'(1) == total) state <= S_CHECK;
                end
              endcase
            end
          end
          S_CHECK: begin
            if (accept) begin
              if (in_byte == csum) begin
                state <= S_DONE;
                run   <= 1'b1;
                done  <= 1'b1;
              end else begin
                state    <= S_ERROR;
                err      <= 1'b1;
                err_code <= 2'b01;
              end
            end
          end
          S_DONE: begin
            if (accept && in_byte == 8'hA5) begin
              run   <= 1'b0;
              done  <= 1'b0;
              state <= S_COUNT;
            end
          end
          S_ERROR: begin
            if (clr) begin
              state    <= S_IDLE;
              err      <= 1'b0;
              err_code <= 2'b00;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes
// into a queue, a negedge monitor pops and compares on every im_we pulse.
module tb_prog_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_byte = 8'h00;
  logic              clr = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              run, done, err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .clr(clr), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .run(run), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_we   = 0;

  logic [7:0] good_frame [11] = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.a = ADDR_W'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every write pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst && im_we) begin
      wr_t e;
      n_we++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        if (im_addr !== e.a || im_wdata !== e.d) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr, im_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: got in_ready=0 expected 1 for byte %h", b);
    end
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_good();
    push_wr(0, 32'h12345678);
    push_wr(1, 32'hDEADBEEF);
    for (int i = 0; i < 11; i++) send(good_frame[i]);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int we0;
    logic [7:0] x;

    // Reset state
    #1;
    chk("reset_outputs", {im_we, im_addr, im_wdata, run, done, err, err_code, words_loaded}, 64'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Good frame
    send_good();
    chk("good_run", run, 1'b1);
    chk("good_done", done, 1'b1);
    chk("good_words", words_loaded, 9'd2);
    chk("good_sb_empty", exp_q.size(), 0);

    // Reload into bad checksum
    push_wr(0, 32'h12345678);
    push_wr(1, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) send(good_frame[i]);
    send(8'h2B);
    chk("bad_err", err, 1'b1);
    chk("bad_code", err_code, 2'b01);
    chk("bad_run", run, 1'b0);
    chk("bad_ready", in_ready, 1'b0);
    chk("bad_sb_empty", exp_q.size(), 0);
    pulse_clr();
    chk("clr_err", err, 1'b0);
    chk("clr_code", err_code, 2'b00);
    chk("clr_ready", in_ready, 1'b1);

    // Leading garbage then good frame
    we0 = n_we;
    send(8'h00); send(8'hFF); send(8'h13);
    chk("garbage_no_we", n_we - we0, 0);
    send_good();
    chk("garb_run", run, 1'b1);
    chk("garb_done", done, 1'b1);
    chk("garb_words", words_loaded, 9'd2);

    // Reload from DONE with full count
    send(8'hA5);
    chk("reload_run_drop", run, 1'b0);
    chk("reload_done_drop", done, 1'b0);
    send(8'h00);
    x = 8'h00;
    we0 = n_we;
    for (int i = 0; i < 256; i++) begin
      push_wr(i, 32'(i));
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
      x = x ^ 8'(i);
    end
    send(x);
    chk("full_writes", n_we - we0, 256);
    chk("full_words", words_loaded, 9'd256);
    chk("full_run", run, 1'b1);
    chk("full_addr_wrap", im_addr, 8'd0);
    chk("full_sb_empty", exp_q.size(), 0);

    // Timeout in DATA
    we0 = n_we;
    send(8'hA5); send(8'h01); send(8'h78);
    begin
      int n = 0;
      while (!err && n < TIMEOUT + 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("to_cycles_min", (n >= TIMEOUT), 1'b1);
    end
    chk("to_err", err, 1'b1);
    chk("to_code", err_code, 2'b10);
    chk("to_no_we", n_we - we0, 0);
    chk("to_run", run, 1'b0);
    pulse_clr();
    chk("to_clr_ready", in_ready, 1'b1);

    // Reset mid-DATA after 5 payload bytes
    push_wr(0, 32'h12345678);
    for (int i = 0; i < 7; i++) send(good_frame[i]);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {im_we, im_addr, im_wdata, run, done, err, err_code, words_loaded}, 64'd0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_sb_empty", exp_q.size(), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send_good();
    chk("post_run", run, 1'b1);
    chk("post_words", words_loaded, 9'd2);
    chk("post_sb_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
